// File: rtl/reg_dump.sv
// Debug readout engine: walks the register file through a dedicated read port and
// streams a sync byte followed by every register, LSB first, over a byte ready/valid port.
module reg_dump #(
    parameter int         NUM_REGS     = 32,
    parameter int         READ_LATENCY = 1,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rf_ra,
    input  logic [31:0] rf_rd,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_ADDR = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [4:0] LAST_IDX  = 5'(NUM_REGS - 1);
    localparam logic [1:0] LAST_WAIT = 2'(READ_LATENCY - 1);

    state_t      state, state_nx;
    logic [4:0]  idx, idx_nx;
    logic [1:0]  bidx, bidx_nx;
    logic [1:0]  wcnt, wcnt_nx;
    logic [31:0] word, word_nx;
    logic [4:0]  ra_nx;
    logic        xfer;

    // Byte handshake: out_valid/out_data are a pure function of registered state, so
    // they hold while out_ready is low; a byte moves on a rising edge with both high.
    assign xfer      = out_valid && out_ready;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            bidx  <= '0;
            wcnt  <= '0;
            word  <= '0;
            rf_ra <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            bidx  <= bidx_nx;
            wcnt  <= wcnt_nx;
            word  <= word_nx;
            rf_ra <= ra_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        bidx_nx   = bidx;
        wcnt_nx   = wcnt;
        word_nx   = word;
        ra_nx     = rf_ra;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        out_valid = (state == S_HDR) || (state == S_SEND);
        out_data  = 8'h00;
        if (state == S_HDR)
            out_data = HEADER;
        else if (state == S_SEND)
            out_data = word[{bidx, 3'b000} +: 8];

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_HDR;
                    idx_nx   = '0;
                    bidx_nx  = '0;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    state_nx = S_ADDR;
                    wcnt_nx  = '0;
                    ra_nx    = idx;
                end
            end
            S_ADDR: begin
                // The read port is given READ_LATENCY cycles before the word is snapshotted.
                if (wcnt == LAST_WAIT) begin
                    word_nx  = rf_rd;
                    bidx_nx  = '0;
                    state_nx = S_SEND;
                end else begin
                    wcnt_nx = wcnt + 2'd1;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    bidx_nx = bidx + 2'd1;
                    if (bidx == 2'd3) begin
                        if (idx == LAST_IDX) begin
                            state_nx = S_DONE;
                        end else begin
                            idx_nx   = idx + 5'd1;
                            ra_nx    = idx + 5'd1;
                            wcnt_nx  = '0;
                            state_nx = S_ADDR;
                        end
                    end
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
                ra_nx    = '0;
            end
            default: begin
                state_nx = S_IDLE;
                ra_nx    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_dump.sv
// Bench for reg_dump: a default instance (32 regs, latency 1) and a small instance
// (4 regs, latency 2), each compared against a byte-stream model built from register values.
module tb_reg_dump;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- default instance
    logic        start_a = 1'b0;
    logic        busy_a, done_a, out_valid_a;
    logic        out_ready_a = 1'b1;
    logic [4:0]  rf_ra_a;
    logic [31:0] rf_rd_a;
    logic [7:0]  out_data_a;
    logic [2:0]  st_a;
    logic [31:0] mem_a [32];
    assign rf_rd_a = mem_a[rf_ra_a];

    reg_dump dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .rf_ra(rf_ra_a), .rf_rd(rf_rd_a), .out_data(out_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .dbg_state(st_a)
    );

    // ---------------- small instance, register file with two-cycle read latency
    logic        start_b = 1'b0;
    logic        busy_b, done_b, out_valid_b;
    logic        out_ready_b = 1'b1;
    logic [4:0]  rf_ra_b, ra_b_d;
    logic [31:0] rf_rd_b;
    logic [7:0]  out_data_b;
    logic [2:0]  st_b;
    logic [31:0] mem_b [32];
    always @(posedge clk) ra_b_d <= rf_ra_b;
    assign rf_rd_b = mem_b[ra_b_d];

    reg_dump #(.NUM_REGS(4), .READ_LATENCY(2), .HEADER(8'hA5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .rf_ra(rf_ra_b), .rf_rd(rf_rd_b), .out_data(out_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .dbg_state(st_b)
    );

    // ---------------- scoreboard state
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] got_b_q[$];
    logic [31:0] snap [32];
    int nbytes_a = 0, busy_a_cyc = 0, done_a_cnt = 0, stall_a_cyc = 0;
    int busy_b_cyc = 0, done_b_cnt = 0;
    bit rdy_rand = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected stream: sync byte, then each register value split into bytes, LSB first.
    task automatic build_exp(input int n);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int r = 0; r < n; r++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back(8'((snap[r] >> (8 * b)) & 32'hFF));
    endtask

    task automatic compare_stream(input bit sel);
        int n;
        n = sel ? got_b_q.size() : got_q.size();
        check(sel ? "stream_len_b" : "stream_len_a", 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++)
            check($sformatf("%s_byte%0d", sel ? "b" : "a", i),
                  32'(sel ? got_b_q[i] : got_q[i]), 32'(exp_q[i]));
    endtask

    // ---------------- driver tasks (all run at posedge + 1)
    always @(posedge clk) begin
        #1;
        out_ready_a = rdy_rand ? ($urandom_range(0, 9) > 2) : 1'b1;
    end

    task automatic clear_a();
        got_q.delete();
        nbytes_a = 0; busy_a_cyc = 0; done_a_cnt = 0; stall_a_cyc = 0;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int budget);
        int c0;
        c0 = sel ? done_b_cnt : done_a_cnt;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if ((sel ? done_b_cnt : done_a_cnt) != c0) return;
        end
        check(sel ? "done_timeout_b" : "done_timeout_a", 32'd0, 32'd1);
    endtask

    task automatic wait_bytes_a(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (nbytes_a >= n) return;
            @(posedge clk); #1;
        end
        check("bytes_timeout_a", 32'(nbytes_a), 32'(n));
    endtask

    // ---------------- monitors (negedge, away from the active edge)
    bit         stall_prev = 1'b0;
    bit         rst_prev = 1'b1;
    logic [7:0] data_prev = 8'h00;
    logic [2:0] state_prev = 3'd0;

    always @(negedge clk) begin
        if (!rst_prev && stall_prev) begin
            check("stall_valid", 32'(out_valid_a), 32'd1);
            check("stall_data", 32'(out_data_a), 32'(data_prev));
            check("stall_state", 32'(st_a), 32'(state_prev));
        end
        if (!rst) begin
            if (out_valid_a && out_ready_a) begin
                got_q.push_back(out_data_a);
                nbytes_a++;
            end
            if (busy_a) busy_a_cyc++;
            if (out_valid_a && !out_ready_a) stall_a_cyc++;
        end
        if (done_a) done_a_cnt++;
        stall_prev = out_valid_a && !out_ready_a;
        data_prev  = out_data_a;
        state_prev = st_a;
        rst_prev   = rst;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid_b && out_ready_b) got_b_q.push_back(out_data_b);
            if (busy_b) busy_b_cyc++;
        end
        if (done_b) done_b_cnt++;
    end

    // ---------------- main sequence
    initial begin
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = 32'h1000_0000 + 32'(i);
            mem_b[i] = $urandom;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_valid", 32'(out_valid_a), 32'd0);
        check("rst_data", 32'(out_data_a), 32'd0);
        check("rst_ra", 32'(rf_ra_a), 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Full dump with ready held high
        for (int i = 0; i < 32; i++) snap[i] = mem_a[i];
        build_exp(32);
        clear_a();
        pulse_start(1'b0);
        wait_done(1'b0, 400);
        check("full_busy_cycles", 32'(busy_a_cyc), 32'd162);
        check("full_done_count", 32'(done_a_cnt), 32'd1);
        check("full_idle_after", 32'(busy_a), 32'd0);
        compare_stream(1'b0);

        // Random backpressure: each stalled cycle lengthens the dump by one
        rdy_rand = 1'b1;
        clear_a();
        pulse_start(1'b0);
        wait_done(1'b0, 2000);
        check("bp_busy_cycles", 32'(busy_a_cyc), 32'(162 + stall_a_cyc));
        check("bp_done_count", 32'(done_a_cnt), 32'd1);
        compare_stream(1'b0);
        rdy_rand = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Start while busy is ignored; start right after done is accepted
        clear_a();
        pulse_start(1'b0);
        wait_bytes_a(50, 400);
        pulse_start(1'b0);
        wait_done(1'b0, 400);
        check("mid_start_done_count", 32'(done_a_cnt), 32'd1);
        check("mid_start_idle", 32'(busy_a), 32'd0);
        compare_stream(1'b0);
        clear_a();
        pulse_start(1'b0);
        check("b2b_valid", 32'(out_valid_a), 32'd1);
        check("b2b_header", 32'(out_data_a), 32'hA5);
        check("b2b_busy", 32'(busy_a), 32'd1);
        wait_done(1'b0, 400);
        check("b2b_busy_cycles", 32'(busy_a_cyc), 32'd162);
        compare_stream(1'b0);

        // Reset while x7 byte 2 is on the port
        clear_a();
        pulse_start(1'b0);
        wait_bytes_a(1 + 7 * 4 + 2, 400);
        check("pre_rst_ra", 32'(rf_ra_a), 32'd7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_valid", 32'(out_valid_a), 32'd0);
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_ra", 32'(rf_ra_a), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_a_cnt), 32'd0);
        check("abort_still_idle", 32'(busy_a), 32'd0);
        rdy_rand = 1'b1;
        clear_a();
        pulse_start(1'b0);
        wait_done(1'b0, 2000);
        check("post_rst_busy_cycles", 32'(busy_a_cyc), 32'(162 + stall_a_cyc));
        check("post_rst_done_count", 32'(done_a_cnt), 32'd1);
        compare_stream(1'b0);
        rdy_rand = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Snapshot: x5 rewritten mid-SEND keeps its old bytes, x6 rewritten in ADDR shows new
        for (int i = 0; i < 32; i++) snap[i] = mem_a[i];
        snap[6] = 32'hDEADBEEF;
        build_exp(32);
        clear_a();
        pulse_start(1'b0);
        wait_bytes_a(1 + 5 * 4 + 1, 400);
        mem_a[5] = 32'hDEADBEEF;
        wait_bytes_a(1 + 6 * 4, 400);
        check("x6_addr_ra", 32'(rf_ra_a), 32'd6);
        mem_a[6] = 32'hDEADBEEF;
        wait_done(1'b0, 400);
        compare_stream(1'b0);
        mem_a[5] = 32'h1000_0005;
        mem_a[6] = 32'h1000_0006;

        // Small instance: 4 registers, two-cycle read latency, random contents
        for (int i = 0; i < 32; i++) snap[i] = mem_b[i];
        build_exp(4);
        got_b_q.delete();
        busy_b_cyc = 0;
        done_b_cnt = 0;
        pulse_start(1'b1);
        wait_done(1'b1, 200);
        check("small_busy_cycles", 32'(busy_b_cyc), 32'd26);
        check("small_done_count", 32'(done_b_cnt), 32'd1);
        compare_stream(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_dump.md
# reg_dump

Debug readout engine for the RISC-V core's 32x32 register file. On a start pulse it walks the register file through a dedicated read port, latches each 32-bit value, and streams it as bytes over a ready/valid byte interface, normally to the UART transmitter. It drives the register file's read side while the core owns the write side, and is used for post-halt state inspection.

## Interface

Parameters:
- NUM_REGS, 32: registers dumped, indices 0..NUM_REGS-1; legal range 1..32.
- READ_LATENCY, 1: cycles from rf_ra change to valid rf_rd; legal range 1..4.
- HEADER, 8'hA5: sync byte sent before register data.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: pulse to begin a dump; sampled only in IDLE.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse when the dump completes.
- rf_ra, output, 5: register file read address (registered).
- rf_rd, input, 32: register file read data.
- out_data, output, 8: byte to transmit.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: sink accepts the byte; a transfer occurs on a rising edge with out_valid && out_ready.

## Operation

- State machine: IDLE, HDR, ADDR, SEND, DONE.
- IDLE:
  - busy=0, out_valid=0, rf_ra=0.
  - start=1 -> HDR; clear reg index idx=0 and byte index bidx=0.
- HDR:
  - out_valid=1, out_data=HEADER.
  - On transfer -> ADDR.
- ADDR:
  - rf_ra=idx for the whole state.
  - Stay READ_LATENCY cycles, using a wait counter reset on entry.
  - At the edge ending the last cycle, latch rf_rd into a 32-bit word register, set bidx=0, go SEND.
- SEND:
  - out_valid=1, out_data=word[8*bidx +: 8]; bytes go LSB first.
  - Each transfer increments bidx.
  - On the transfer with bidx=3: if idx==NUM_REGS-1 -> DONE; else idx+1 -> ADDR.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then -> IDLE.
- Stability:
  - While out_valid=1 and out_ready=0, out_data, out_valid and the state must not change.
  - out_valid never drops without a transfer, except on rst.
- Snapshot semantics: the word is latched once per register. Register file writes during SEND do not affect bytes already latched. A write in ADDR before the latch edge is reflected in that register's bytes.
- start is ignored outside IDLE, and no request is queued.
- No special case for x0; it is read and sent like any other register.
- idx width is 5 bits; with NUM_REGS=32 it never wraps past 31.

## Timing

- Reset values, taking effect at the first rising edge with rst=1:
  - State IDLE; busy=0, done=0, out_valid=0.
  - out_data=0, rf_ra=0, idx=0, bidx=0, word=0.
- rst=1 in any state aborts the dump on that edge. No partial completion, no done pulse, and out_valid is low the next cycle.
- start sampled high at edge E0 gives HDR (out_valid=1, busy=1) from E0.
- With out_ready held high and READ_LATENCY=L, cycles in busy states are 1 + NUM_REGS*(L+4) + 1 (DONE).
  - Defaults: 1 + 32*5 + 1 = 162 cycles.
- done rises in the cycle after the last data byte's transfer.
- Back-to-back dumps: start asserted in the cycle after DONE (in IDLE) is accepted. Minimum gap between done and the next HDR is 1 cycle.
- rf_ra changes only on entry to ADDR and on return to IDLE (to 0).

## Test plan

- Preload xN = 32'h1000_0000 + N, ready held high, pulse start. Stream must be A5, 00 00 00 10, 01 00 00 10, ..., 1F 00 00 10 (129 bytes). done pulses once, 162 busy cycles.
- Random backpressure on out_ready at about 30% low. Same byte sequence as above; out_data and out_valid must hold while stalled (check every stalled cycle).
- Pulse start again at byte 50 of a dump. The stream is unchanged and exactly one done occurs. A start in the cycle after done begins a new A5.
- Assert rst during SEND of x7 byte 2. The next cycle shows out_valid=0, busy=0, rf_ra=0, and done never pulses. A later start produces a full, correct stream.
- Overwrite x5 with 32'hDEADBEEF while x5 is in SEND after byte 0. The x5 bytes stay at the old value. A write during ADDR of x6 appears as EF BE AD DE.
- Set NUM_REGS=4, READ_LATENCY=2 with a model register file of 2-cycle latency. Stream is A5 plus 16 bytes of x0..x3. Busy lasts 1+4*6+1=26 cycles with ready high.
